// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage
// RISC-V instruction decode stage. It decodes one instruction per cycle, reads
// the register file (writeback values are bypassed into the operands in the
// same cycle) and detects load-use hazards. Results go out through a
// registered ID/EX slot with valid/ready flow control on both sides.
module pipelined_decode_stage #(
   parameter int XLEN       = 32,
   parameter int REG_COUNT  = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [XLEN-1:0]       in_pc,
   input  logic                  flush,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [XLEN-1:0]       out_rs1_val,
   output logic [XLEN-1:0]       out_rs2_val,
   output logic [XLEN-1:0]       out_imm,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_reg_write,
   output logic                  out_alu_src,
   output logic [3:0]            out_alu_op,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_illegal
);

   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // An index is legal only when it names an implemented register (RV32E has 16).
   function automatic logic idx_ok(input logic [REG_ADDR_W-1:0] idx);
      return 32'(idx) < REG_COUNT;
   endfunction

   // Instruction fields
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign rd     = in_instr[11:7];

   // Per-format immediates, all sign-extended from instr[31]
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   // Decoded control
   logic            dec_reg_write, dec_alu_src, dec_mem_read, dec_mem_write;
   logic            dec_illegal, dec_opc_ok;
   logic            dec_uses_rs1, dec_uses_rs2, dec_uses_rd;
   logic [3:0]      dec_alu_op;
   logic [XLEN-1:0] dec_imm;

   // Opcode decode: control bits, immediate select and which register fields are live
   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      dec_imm       = '0;
      dec_reg_write = 1'b0;
      dec_alu_src   = 1'b0;
      dec_alu_op    = 4'b0000;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_opc_ok    = 1'b1;
      dec_uses_rs1  = 1'b0;
      dec_uses_rs2  = 1'b0;
      dec_uses_rd   = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            dec_imm = imm_u; dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_uses_rd = 1'b1;
         end
         OPC_JAL: begin
            dec_imm = imm_j; dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_uses_rd = 1'b1;
         end
         OPC_JALR: begin
            dec_imm = imm_i; dec_reg_write = 1'b1; dec_alu_src = 1'b1;
            dec_uses_rs1 = 1'b1; dec_uses_rd = 1'b1;
         end
         OPC_BRANCH: begin
            dec_imm = imm_b; dec_alu_op = {1'b0, funct3};
            dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1;
         end
         OPC_LOAD: begin
            dec_imm = imm_i; dec_mem_read = 1'b1; dec_reg_write = 1'b1; dec_alu_src = 1'b1;
            dec_uses_rs1 = 1'b1; dec_uses_rd = 1'b1;
         end
         OPC_STORE: begin
            dec_imm = imm_s; dec_mem_write = 1'b1; dec_alu_src = 1'b1;
            dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1;
         end
         OPC_OP_IMM: begin
            // Only the shift-right immediates use bit 30 to pick arithmetic vs logical.
            dec_imm = imm_i; dec_reg_write = 1'b1; dec_alu_src = 1'b1;
            dec_alu_op = {(funct3 == 3'b101) & in_instr[30], funct3};
            dec_uses_rs1 = 1'b1; dec_uses_rd = 1'b1;
         end
         OPC_OP: begin
            dec_reg_write = 1'b1; dec_alu_op = {in_instr[30], funct3};
            dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1; dec_uses_rd = 1'b1;
         end
         OPC_SYSTEM: begin
            dec_imm = imm_i;
         end
         default: dec_opc_ok = 1'b0;
      endcase

      dec_illegal = !dec_opc_ok
                    || (dec_uses_rs1 && !idx_ok(rs1))
                    || (dec_uses_rs2 && !idx_ok(rs2))
                    || (dec_uses_rd  && !idx_ok(rd));

      // Illegal instructions must not change architectural state.
      if (dec_illegal) begin
         dec_reg_write = 1'b0;
         dec_mem_read  = 1'b0;
         dec_mem_write = 1'b0;
      end
      if (rd == '0) dec_reg_write = 1'b0;
   end

   // Register file
   logic [XLEN-1:0] regs [REG_COUNT];
   logic [XLEN-1:0] rs1_val, rs2_val;

   // Operand read with same-cycle bypass from writeback; x0 and unimplemented indices read 0
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != '0 && idx_ok(rs1))
         rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1[IDX_W-1:0]];
      if (rs2 != '0 && idx_ok(rs2))
         rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2[IDX_W-1:0]];
   end

   // Writeback port; x0 is never written
   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the register file is reset because all architectural registers must read 0 after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (wb_en && wb_rd != '0 && idx_ok(wb_rd)) begin
         regs[wb_rd[IDX_W-1:0]] <= wb_data;
      end
   end

   // Load-use hazard tracking
   logic                  load_pending;
   logic [REG_ADDR_W-1:0] load_rd;
   logic                  stall, accept, xfer, load_set;

   assign stall    = load_pending && in_valid
                     && ((dec_uses_rs1 && rs1 == load_rd) || (dec_uses_rs2 && rs2 == load_rd));
   assign in_ready = (!out_valid || out_ready) && !stall && !flush;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign load_set = !flush && xfer && out_mem_read && out_rd != '0;

   // A load leaving ID/EX arms the tracker for exactly one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_pending <= 1'b0;
         load_rd      <= '0;
      end else begin
         load_pending <= load_set;
         if (load_set) load_rd <= out_rd;
      end
   end

   // ID/EX register: flush drains, accept loads, a drained slot goes empty, otherwise hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_rs1_val   <= '0;
         out_rs2_val   <= '0;
         out_imm       <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         out_alu_src   <= 1'b0;
         out_alu_op    <= 4'b0000;
         out_mem_read  <= 1'b0;
         out_mem_write <= 1'b0;
         out_illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_pc        <= in_pc;
         out_rs1_val   <= rs1_val;
         out_rs2_val   <= rs2_val;
         out_imm       <= dec_imm;
         out_rd        <= rd;
         out_reg_write <= dec_reg_write;
         out_alu_src   <= dec_alu_src;
         out_alu_op    <= dec_alu_op;
         out_mem_read  <= dec_mem_read;
         out_mem_write <= dec_mem_write;
         out_illegal   <= dec_illegal;
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Bench for pipelined_decode_stage: directed steps from the test plan followed by
// randomized traffic, all compared against a cycle-level reference model.
// A second instance (XLEN=64, REG_COUNT=16) covers wide immediates and RV32E indices.
module tb_pipelined_decode_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0, in_pc = '0, wb_data = '0;
   logic [4:0]  wb_rd = '0;

   logic        in_ready, out_valid, out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_illegal;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [4:0]  out_rd;
   logic [3:0]  out_alu_op;

   logic        w_in_ready, w_out_valid, w_out_reg_write, w_out_alu_src, w_out_mem_read;
   logic        w_out_mem_write, w_out_illegal;
   logic [63:0] w_out_pc, w_out_rs1_val, w_out_rs2_val, w_out_imm, w_in_pc, w_wb_data;
   logic [4:0]  w_out_rd;
   logic [3:0]  w_out_alu_op;

   assign w_in_pc   = {32'b0, in_pc};
   assign w_wb_data = {32'b0, wb_data};

   pipelined_decode_stage #(.XLEN(32), .REG_COUNT(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1_val(out_rs1_val),
      .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_alu_src(out_alu_src), .out_alu_op(out_alu_op), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_illegal(out_illegal)
   );

   pipelined_decode_stage #(.XLEN(64), .REG_COUNT(16), .REG_ADDR_W(5)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
      .in_pc(w_in_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(w_wb_data),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_rs1_val(w_out_rs1_val),
      .out_rs2_val(w_out_rs2_val), .out_imm(w_out_imm), .out_rd(w_out_rd),
      .out_reg_write(w_out_reg_write), .out_alu_src(w_out_alu_src), .out_alu_op(w_out_alu_op),
      .out_mem_read(w_out_mem_read), .out_mem_write(w_out_mem_write), .out_illegal(w_out_illegal)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] pc = 32'h0000_1000;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] imm;
      logic [3:0]  op;
      bit rw, src, mr, mw, ill, u1, u2;
   } dec_t;

   typedef struct {
      logic [31:0] pc, rs1v, rs2v, imm;
      logic [4:0]  rd;
      logic [3:0]  op;
      bit rw, src, mr, mw, ill;
   } out_t;

   bit          m_valid;
   out_t        m_out;
   bit          m_lp;
   logic [4:0]  m_lrd;
   logic [31:0] m_regs [32];

   function automatic dec_t decode(input logic [31:0] ins);
      dec_t d;
      logic [31:0] sx, im_i, im_s, im_b, im_u, im_j;
      logic [2:0]  f3;
      sx   = ins[31] ? 32'hFFFF_FFFF : 32'h0;
      im_i = (sx << 12) | (ins >> 20);
      im_s = (sx << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
      im_b = (sx << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
             | (((ins >> 8) & 32'hF) << 1);
      im_u = ins & 32'hFFFF_F000;
      im_j = (sx << 20) | (ins & 32'h000F_F000) | (((ins >> 20) & 32'h1) << 11)
             | (((ins >> 21) & 32'h3FF) << 1);
      f3 = ins[14:12];
      d.imm = 0; d.op = 0; d.rw = 0; d.src = 0; d.mr = 0; d.mw = 0; d.ill = 0; d.u1 = 0; d.u2 = 0;
      case (ins[6:0])
         7'b0110111, 7'b0010111: begin d.imm = im_u; d.rw = 1; d.src = 1; end
         7'b1101111: begin d.imm = im_j; d.rw = 1; d.src = 1; end
         7'b1100111: begin d.imm = im_i; d.rw = 1; d.src = 1; d.u1 = 1; end
         7'b1100011: begin d.imm = im_b; d.op = {1'b0, f3}; d.u1 = 1; d.u2 = 1; end
         7'b0000011: begin d.imm = im_i; d.mr = 1; d.rw = 1; d.src = 1; d.u1 = 1; end
         7'b0100011: begin d.imm = im_s; d.mw = 1; d.src = 1; d.u1 = 1; d.u2 = 1; end
         7'b0010011: begin
            d.imm = im_i; d.rw = 1; d.src = 1; d.u1 = 1;
            d.op = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
         end
         7'b0110011: begin d.rw = 1; d.op = {ins[30], f3}; d.u1 = 1; d.u2 = 1; end
         7'b1110011: begin d.imm = im_i; end
         default:    d.ill = 1;
      endcase
      if (d.ill) begin d.rw = 0; d.mr = 0; d.mw = 0; end
      return d;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] idx);
      if (idx == 0) return 32'h0;
      if (wb_en && wb_rd == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic bit model_ready();
      dec_t d;
      bit hz;
      d  = decode(in_instr);
      hz = m_lp && in_valid && ((d.u1 && in_instr[19:15] == m_lrd) || (d.u2 && in_instr[24:20] == m_lrd));
      return (!m_valid || out_ready) && !hz && !flush;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_lp = 0; m_lrd = 0;
      m_out.pc = 0; m_out.rs1v = 0; m_out.rs2v = 0; m_out.imm = 0; m_out.rd = 0; m_out.op = 0;
      m_out.rw = 0; m_out.src = 0; m_out.mr = 0; m_out.mw = 0; m_out.ill = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
   endtask

   task automatic model_edge();
      dec_t d;
      bit rdy, xf, nlp;
      logic [4:0] nlrd;
      d    = decode(in_instr);
      rdy  = model_ready();
      xf   = m_valid && out_ready;
      nlp  = !flush && xf && m_out.mr && m_out.rd != 0;
      nlrd = m_out.rd;
      if (flush) m_valid = 0;
      else if (in_valid && rdy) begin
         m_valid    = 1;
         m_out.pc   = in_pc;
         m_out.rs1v = operand(in_instr[19:15]);
         m_out.rs2v = operand(in_instr[24:20]);
         m_out.imm  = d.imm;
         m_out.rd   = in_instr[11:7];
         m_out.op   = d.op;
         m_out.rw   = d.rw && in_instr[11:7] != 0;
         m_out.src  = d.src;
         m_out.mr   = d.mr;
         m_out.mw   = d.mw;
         m_out.ill  = d.ill;
      end else if (xf) m_valid = 0;
      m_lp = nlp;
      if (nlp) m_lrd = nlrd;
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
   endtask

   task automatic check_outputs();
      check("out_valid",     out_valid,     m_valid);
      check("out_pc",        out_pc,        m_out.pc);
      check("out_rs1_val",   out_rs1_val,   m_out.rs1v);
      check("out_rs2_val",   out_rs2_val,   m_out.rs2v);
      check("out_imm",       out_imm,       m_out.imm);
      check("out_rd",        out_rd,        m_out.rd);
      check("out_reg_write", out_reg_write, m_out.rw);
      check("out_alu_src",   out_alu_src,   m_out.src);
      check("out_alu_op",    out_alu_op,    m_out.op);
      check("out_mem_read",  out_mem_read,  m_out.mr);
      check("out_mem_write", out_mem_write, m_out.mw);
      check("out_illegal",   out_illegal,   m_out.ill);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl,
                        input bit we, input logic [4:0] wrd, input logic [31:0] wd);
      in_valid = iv; in_instr = ins; in_pc = pc; pc += 4;
      out_ready = ordy; flush = fl; wb_en = we; wb_rd = wrd; wb_data = wd;
   endtask

   // Inputs are applied at a falling edge; one rising edge later outputs are compared.
   task automatic cycle();
      bit rdy;
      #1;
      rdy = model_ready();
      if (in_valid) check("in_ready", in_ready, rdy);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   localparam logic [31:0] I_ADDI    = 32'hFFF2_8313; // addi x6,x5,-1
   localparam logic [31:0] I_BEQ     = 32'hFE00_0EE3; // beq  x0,x0,-4
   localparam logic [31:0] I_LW      = 32'h0000_A383; // lw   x7,0(x1)
   localparam logic [31:0] I_ADD_DEP = 32'h0023_8433; // add  x8,x7,x2
   localparam logic [31:0] I_ADDI9   = 32'h0050_0493; // addi x9,x0,5
   localparam logic [31:0] I_ADD_X3  = 32'h0001_8233; // add  x4,x3,x0
   localparam logic [31:0] I_ADD_X0  = 32'h0000_05B3; // add  x11,x0,x0
   localparam logic [31:0] I_ADD_X10 = 32'h0005_05B3; // add  x11,x10,x0
   localparam logic [31:0] I_BAD_OPC = 32'h0000_02FF; // opcode 0x7F
   localparam logic [31:0] I_ADD_X20 = 32'h0020_8A33; // add  x20,x1,x2

   logic [6:0] pool [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011,
                             7'b1111111, 7'b0001011};

   initial begin
      logic [31:0] ins;
      model_reset();

      // Reset state
      @(negedge clk); @(negedge clk);
      check_outputs();
      check("w_out_valid_rst", w_out_valid, 1'b0);
      rst = 1'b1;
      #1 check("in_ready_after_rst", in_ready, 1'b1);

      // 1: writeback x5, then ADDI reads it from the file
      drive(0, 32'h0, 1, 0, 1, 5'd5, 32'h0000_1234); cycle();
      drive(1, I_ADDI, 1, 0, 0, 5'd0, 32'h0);        cycle();
      check("t1_valid", out_valid, 1'b1);
      check("t1_rs1",   out_rs1_val, 32'h0000_1234);
      check("t1_imm",   out_imm, 32'hFFFF_FFFF);
      check("t1_src",   out_alu_src, 1'b1);
      check("t1_rd",    out_rd, 5'd6);
      check("t1_rw",    out_reg_write, 1'b1);
      check("t1_imm64", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

      // 2: B-type immediate, 32 and 64 bit
      drive(1, I_BEQ, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t2_imm",   out_imm, 32'hFFFF_FFFC);
      check("t2_rw",    out_reg_write, 1'b0);
      check("t2_op",    out_alu_op, 4'b0000);
      check("t2_imm64", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

      // 3: load-use stall for exactly one cycle
      drive(1, I_LW, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t3_lw_mr", out_mem_read, 1'b1);
      drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0); cycle();
      drive(1, I_ADD_DEP, 1, 0, 0, 5'd0, 32'h0);
      #1 check("t3_stall_ready", in_ready, 1'b0);
      cycle();
      check("t3_bubble", out_valid, 1'b0);
      drive(1, I_ADD_DEP, 1, 0, 0, 5'd0, 32'h0);
      #1 check("t3_release_ready", in_ready, 1'b1);
      cycle();
      check("t3_issue_valid", out_valid, 1'b1);
      check("t3_issue_rd", out_rd, 5'd8);

      // 4: back-pressure holds ID/EX stable
      for (int k = 0; k < 3; k++) begin
         drive(1, I_ADDI9, 0, 0, 0, 5'd0, 32'h0);
         #1 check("t4_hold_ready", in_ready, 1'b0);
         cycle();
         check("t4_hold_valid", out_valid, 1'b1);
         check("t4_hold_rd", out_rd, 5'd8);
      end
      drive(1, I_ADDI9, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t4_load_rd", out_rd, 5'd9);
      check("t4_load_imm", out_imm, 32'd5);

      // 5: writeback bypass, and x0 stays zero
      drive(1, I_ADD_X3, 1, 0, 1, 5'd3, 32'hA5A5_A5A5); cycle();
      check("t5_bypass_rs1", out_rs1_val, 32'hA5A5_A5A5);
      check("t5_bypass_rs2", out_rs2_val, 32'h0);
      drive(1, I_ADD_X0, 1, 0, 1, 5'd0, 32'hDEAD_BEEF); cycle();
      check("t5_x0_bypass", out_rs1_val, 32'h0);
      drive(1, I_ADD_X0, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t5_x0_file", out_rs1_val, 32'h0);
      drive(1, I_ADD_X3, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t5_x3_file", out_rs1_val, 32'hA5A5_A5A5);

      // 6: flush drops the presented instruction; writeback still commits
      drive(1, I_ADDI9, 0, 1, 1, 5'd10, 32'h0000_0077);
      #1 check("t6_flush_ready", in_ready, 1'b0);
      cycle();
      check("t6_flush_valid", out_valid, 1'b0);
      drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t6_not_issued", out_valid, 1'b0);
      drive(1, I_ADD_X10, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("t6_wb_committed", out_rs1_val, 32'h0000_0077);

      // Illegal opcode and RV32E register index
      drive(1, I_BAD_OPC, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("ill_opc", out_illegal, 1'b1);
      check("ill_opc_rw", out_reg_write, 1'b0);
      drive(1, I_ADD_X20, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("x20_legal32", out_illegal, 1'b0);
      check("x20_rw32", out_reg_write, 1'b1);
      check("x20_valid16", w_out_valid, 1'b1);
      check("x20_illegal16", w_out_illegal, 1'b1);
      check("x20_rw16", w_out_reg_write, 1'b0);

      // Randomized traffic with dense register reuse to provoke hazards and bypasses
      for (int k = 0; k < 400; k++) begin
         ins        = $urandom();
         ins[6:0]   = pool[$urandom_range(0, 11)];
         ins[11:7]  = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
               $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom());
         cycle();
      end

      // Asynchronous reset in the middle of a load-use stall
      drive(0, 32'h0, 1, 1, 0, 5'd0, 32'h0); cycle();
      drive(1, I_LW, 1, 0, 0, 5'd0, 32'h0);  cycle();
      drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0); cycle();
      drive(1, I_ADD_DEP, 1, 0, 0, 5'd0, 32'h0);
      #1 check("rst_stall_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check("rst_w_valid", w_out_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(1, I_ADD_X3, 1, 0, 0, 5'd0, 32'h0); cycle();
      check("rst_regs_zero", out_rs1_val, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_decode_stage.md
Name: pipelined_decode_stage

Overview:
- Parametrised successor of the single-cycle decode block. Decodes one RISC-V instruction per cycle with full per-format immediate generation.
- Reads the internal register file, with write-through bypass from writeback.
- Detects load-use hazards and presents results through a registered ID/EX output with valid/ready handshakes on both sides.
- Sits between the fetch stage and the execute stage of the pipelined core.

Parameters:
- XLEN, 32, datapath width (32 or 64); register values, PC and immediate width.
- REG_COUNT, 32, architectural registers (32 for RV32I/RV64I, 16 for RV32E); x0 is hardwired zero.
- REG_ADDR_W, 5, register index width (fixed at 5; indices >= REG_COUNT are illegal).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  squash the stage (branch mispredict/trap).
- wb_en  in  1  writeback write enable.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute accepts ID/EX contents.
- out_pc  out  XLEN  registered PC.
- out_rs1_val, out_rs2_val  out  XLEN  operand values.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  5  destination index.
- out_reg_write  out  1  instruction writes rd (forced 0 when rd==0).
- out_alu_src  out  1  0 = rs2, 1 = immediate.
- out_alu_op  out  4  {alt bit, funct3}.
- out_mem_read, out_mem_write  out  1  load / store.
- out_illegal  out  1  unsupported opcode or register index.

Behaviour:
- Reset (rst low, asynchronous): every output register is 0, including out_valid and all payload fields. All registers read 0. Load tracker is cleared. in_ready is 1 once rst deasserts.
- Immediates, sign-extended from instr[31] to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: 0.
- Opcode handling:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: reg_write=1, alu_src=1, alu_op=0000.
  - BRANCH 1100011: reg_write=0, alu_src=0, alu_op={0,funct3}.
  - LOAD 0000011: mem_read=1, reg_write=1, alu_src=1, alu_op=0000.
  - STORE 0100011: mem_write=1, alu_src=1, alu_op=0000.
  - OP-IMM 0010011: alu_src=1; alt bit = instr[30] only when funct3==101, else 0.
  - OP 0110011: alu_src=0; alt bit = instr[30].
  - SYSTEM 1110011: reg_write=0, no other effect.
  - Any other opcode, or rs1/rs2/rd >= REG_COUNT: illegal=1; reg_write, mem_read and mem_write all 0.
- Register file:
  - Synchronous write on wb_en with wb_rd != 0; writes to x0 are ignored.
  - Combinational read.
  - Bypass: if wb_en, wb_rd == rs and rs != 0, the operand takes wb_data in the same cycle.
  - x0 always reads 0.
- Load-use hazard:
  - When an ID/EX transfer (out_valid & out_ready) carries mem_read=1 and rd != 0, latch load_rd and set load_pending for exactly the next cycle.
  - During that cycle, if the incoming instruction uses rs1 == load_rd, or rs2 == load_rd (R/S/B formats only), then stall: in_ready=0 and a bubble is inserted (out_valid becomes 0 after the transfer).
  - load_pending clears unconditionally after one cycle.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !stall & !flush.
  - Accept when in_valid & in_ready: load all ID/EX fields and set out_valid=1. Latency is 1 cycle.
  - If out_valid & out_ready and nothing is accepted: out_valid <= 0.
  - If out_valid & !out_ready: all ID/EX fields hold stable.
- Flush has priority over everything except reset:
  - Next edge: out_valid=0, load_pending=0.
  - Any instruction presented that cycle is dropped.
  - A writeback in the same cycle still commits.
- Simultaneous writeback and read of the same register: the bypass value is used and the file updates on the same edge.

Test Plan:
1. Reset, then wb x5=0x1234. Present ADDI x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, rs1_val=0x1234, imm=0xFFFFFFFF, alu_src=1, rd=6, reg_write=1.
2. B-type BEQ with offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC, reg_write=0, alu_op=0000. With XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
3. Issue LW x7,0(x1) accepted by execute, then ADD x8,x7,x2 -> in_ready=0 for exactly 1 cycle, one bubble (out_valid=0), ADD issues the following cycle.
4. Hold out_ready=0 for 3 cycles with out_valid=1 -> all outputs stable, in_ready=0. Release -> next instruction loads on the following edge.
5. wb_en=1, wb_rd=3, wb_data=0xA5A5A5A5 in the same cycle ADD x4,x3,x0 is accepted -> rs1_val=0xA5A5A5A5, rs2_val=0. Writing wb_rd=0 leaves x0 reading 0.
6. Assert flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the instruction is not issued. Opcode 0x7F, or x20 with REG_COUNT=16 -> out_illegal=1, reg_write=0. Pulse rst low mid-stall -> all outputs 0 immediately.
